// File: rtl/inst_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch unit: bus widths, stall index,
// exception bit positions and the response classification used by the top.
package inst_fetch_unit_pkg;

    localparam int INST_ADDR_W  = 32;
    localparam int INST_W       = 32;
    localparam int STALL_BUS_W  = 6;
    localparam int STALL_IF_IDX = 1;
    localparam int QUEUE_DEPTH  = 2;
    localparam int EXC_ADEL_BIT = 4;

    localparam logic [INST_ADDR_W-1:0] RESET_PC = 32'hbfc0_0000;

    // What a data_ok beat does in the current cycle.
    typedef enum logic [1:0] {
        RESP_IDLE,
        RESP_DROP,
        RESP_FILL
    } resp_action_e;

    function automatic logic [31:0] exc_vector(input logic adel);
        logic [31:0] v;
        v               = '0;
        v[EXC_ADEL_BIT] = adel;
        return v;
    endfunction

endpackage

// File: rtl/inst_fetch_unit_if.sv
// SRAM-like instruction-memory read port: request/address handshake followed by
// in-order data_ok beats. The fetch unit is the master, the memory the slave.
interface inst_fetch_unit_if
    import inst_fetch_unit_pkg::*;
#(
    parameter int ADDR_W = INST_ADDR_W,
    parameter int DATA_W = INST_W
);

    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              addr_ok;
    logic              data_ok;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req,
        output addr,
        input  addr_ok,
        input  data_ok,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output addr_ok,
        output data_ok,
        output rdata
    );

endinterface

// File: rtl/inst_fetch_unit_fetch_queue.sv
// In-order circular buffer of fetch entries {pc, inst, done, adel}: allocate at
// tail, fill the oldest not-done entry, pop at head, clear everything on flush.
module inst_fetch_unit_fetch_queue
    import inst_fetch_unit_pkg::*;
#(
    parameter  int ADDR_W = INST_ADDR_W,
    parameter  int DATA_W = INST_W,
    parameter  int DEPTH  = QUEUE_DEPTH,
    localparam int PW     = $clog2(DEPTH),
    localparam int CW     = PW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              alloc,
    input  logic [ADDR_W-1:0] alloc_pc,
    input  logic              alloc_adel,
    input  logic              fill,
    input  logic [DATA_W-1:0] fill_data,
    input  logic              pop,
    output logic              head_done,
    output logic [ADDR_W-1:0] head_pc,
    output logic [DATA_W-1:0] head_inst,
    output logic              head_adel,
    output logic [CW-1:0]     count,
    output logic [CW-1:0]     pending
);

    logic [ADDR_W-1:0] pc_q   [DEPTH];
    logic [DATA_W-1:0] inst_q [DEPTH];
    logic [DEPTH-1:0]  done_q;
    logic [DEPTH-1:0]  adel_q;
    logic [PW-1:0]     head_q;
    logic [PW-1:0]     tail_q;
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     pend_q;

    logic [PW-1:0]     fill_idx;
    logic              fill_hit;
    logic              fill_en;

    // Oldest not-done entry, scanning from head. Misaligned entries are born
    // done, so waiting entries are not necessarily contiguous.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        fill_idx = head_q;
        fill_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!fill_hit && (CW'(i) < count_q) && !done_q[head_q + PW'(i)]) begin
                fill_idx = head_q + PW'(i);
                fill_hit = 1'b1;
            end
        end
    end

    assign fill_en = fill & fill_hit;

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: the storage is only DEPTH entries, so it is reset along with the
        // pointers; head outputs then read as zero straight out of reset.
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            pend_q  <= '0;
            done_q  <= '0;
            adel_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]   <= '0;
                inst_q[i] <= '0;
            end
        end else if (clear) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            pend_q  <= '0;
            done_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register update in this
            // block seeing the pre-edge values, regardless of statement order.
            if (alloc) begin
                pc_q[tail_q]   <= alloc_pc;
                inst_q[tail_q] <= '0;
                done_q[tail_q] <= alloc_adel;
                adel_q[tail_q] <= alloc_adel;
                tail_q         <= tail_q + 1'b1;
            end
            if (fill_en) begin
                inst_q[fill_idx] <= fill_data;
                done_q[fill_idx] <= 1'b1;
            end
            if (pop) begin
                head_q <= head_q + 1'b1;
            end
            count_q <= count_q + CW'(alloc) - CW'(pop);
            pend_q  <= pend_q + CW'(alloc & ~alloc_adel) - CW'(fill_en);
        end
    end

    assign head_done = (count_q != '0) & done_q[head_q];
    assign head_pc   = pc_q[head_q];
    assign head_inst = inst_q[head_q];
    assign head_adel = adel_q[head_q];
    assign count     = count_q;
    assign pending   = pend_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction-fetch responder: turns the PC generator's pc/ce stream into memory
// reads, pairs in-order responses with their PC and presents them to ID.
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter  int ADDR_W    = INST_ADDR_W,
    parameter  int DATA_W    = INST_W,
    parameter  int DEPTH     = QUEUE_DEPTH,
    parameter  int STALL_W   = STALL_BUS_W,
    parameter  int STALL_IDX = STALL_IF_IDX,
    localparam int CW        = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   pc_i,
    input  logic                ce_i,
    output logic                req_ack_o,
    input  logic [STALL_W-1:0]  stall,
    input  logic                flush,
    inst_fetch_unit_if.master   inst_sram,
    output logic                id_valid_o,
    output logic [ADDR_W-1:0]   id_pc_o,
    output logic [DATA_W-1:0]   id_inst_o,
    output logic [31:0]         excepttype_o
);

    logic          misaligned;
    logic          full;
    logic          can_take;
    logic          accept_mem;
    logic          accept_adel;
    logic          pop;
    logic          head_done;
    logic          head_adel;
    logic [CW-1:0] q_count;
    logic [CW-1:0] q_pend;
    logic [CW-1:0] disc_q;
    resp_action_e  resp;
    logic          unused_stall;

    // Responses still owed for flushed requests occupy slots until they drain.
    assign full       = (q_count + disc_q) == CW'(DEPTH);
    assign misaligned = |pc_i[1:0];

    // Gated by rst so the request and acknowledge drop the moment reset asserts.
    assign can_take    = rst & ce_i & ~flush & ~full;
    assign accept_mem  = inst_sram.req & inst_sram.addr_ok;
    assign accept_adel = can_take & misaligned;
    assign req_ack_o   = accept_mem | accept_adel;

    assign inst_sram.req  = can_take & ~misaligned;
    assign inst_sram.addr = rst ? pc_i : '0;

    always_comb begin
        resp = RESP_IDLE;
        if (inst_sram.data_ok) begin
            if (disc_q != '0) begin
                resp = RESP_DROP;
            end else if (q_pend != '0) begin
                resp = RESP_FILL;
            end
        end
    end

    // On flush, every allocated-but-unanswered request becomes a response to
    // discard, less any beat that arrives in the flush cycle itself.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            disc_q <= '0;
        end else if (flush) begin
            disc_q <= disc_q + q_pend - CW'(resp != RESP_IDLE);
        end else if (resp == RESP_DROP) begin
            disc_q <= disc_q - 1'b1;
        end
    end

    inst_fetch_unit_fetch_queue #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .clear      (flush),
        .alloc      (req_ack_o),
        .alloc_pc   (pc_i),
        .alloc_adel (misaligned),
        .fill       ((resp == RESP_FILL) & ~flush),
        .fill_data  (inst_sram.rdata),
        .pop        (pop),
        .head_done  (head_done),
        .head_pc    (id_pc_o),
        .head_inst  (id_inst_o),
        .head_adel  (head_adel),
        .count      (q_count),
        .pending    (q_pend)
    );

    assign id_valid_o   = head_done & ~flush;
    assign pop          = id_valid_o & ~stall[STALL_IDX];
    assign excepttype_o = exc_vector(head_adel);

    // Only the IF bit of the shared stall bus matters here.
    assign unused_stall = ^stall;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: a queue-level model is checked every
// negative edge, plus literal expectations at the interesting cycles.
module tb_inst_fetch_unit;
    import inst_fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_i;
    logic        ce_i;
    logic        req_ack_o;
    logic [5:0]  stall;
    logic        flush;
    logic        id_valid_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic [31:0] excepttype_o;

    inst_fetch_unit_if sram_if ();

    inst_fetch_unit dut (
        .clk          (clk),
        .rst          (rst),
        .pc_i         (pc_i),
        .ce_i         (ce_i),
        .req_ack_o    (req_ack_o),
        .stall        (stall),
        .flush        (flush),
        .inst_sram    (sram_if),
        .id_valid_o   (id_valid_o),
        .id_pc_o      (id_pc_o),
        .id_inst_o    (id_inst_o),
        .excepttype_o (excepttype_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a plain list of fetches in program order plus a count of
    // responses still owed to flushed requests.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        bit          done;
        bit          adel;
    } ent_t;

    ent_t mq[$];
    int   m_disc = 0;

    task automatic model_step();
        bit full, mis, take, e_req, e_ack, e_valid;
        int pend, first;
        full    = (mq.size() + m_disc) >= QUEUE_DEPTH;
        mis     = pc_i[1:0] != 2'b00;
        take    = ce_i && !flush && !full;
        e_req   = take && !mis;
        e_ack   = (e_req && sram_if.addr_ok) || (take && mis);
        e_valid = (mq.size() > 0) && mq[0].done && !flush;
        check("m_req",   {31'b0, sram_if.req}, {31'b0, e_req});
        check("m_addr",  sram_if.addr, pc_i);
        check("m_ack",   {31'b0, req_ack_o}, {31'b0, e_ack});
        check("m_valid", {31'b0, id_valid_o}, {31'b0, e_valid});
        if (e_valid) begin
            check("m_pc",   id_pc_o, mq[0].pc);
            check("m_inst", id_inst_o, mq[0].inst);
            check("m_exc",  excepttype_o, mq[0].adel ? 32'h0000_0010 : 32'h0);
        end
        pend  = 0;
        first = -1;
        foreach (mq[i]) begin
            if (!mq[i].done) begin
                pend++;
                if (first < 0) first = i;
            end
        end
        if (flush) begin
            m_disc = m_disc + pend - ((sram_if.data_ok && (m_disc > 0 || pend > 0)) ? 1 : 0);
            mq.delete();
        end else begin
            if (sram_if.data_ok) begin
                if (m_disc > 0) m_disc--;
                else if (first >= 0) begin
                    mq[first].inst = sram_if.rdata;
                    mq[first].done = 1'b1;
                end
            end
            if (e_valid && !stall[STALL_IF_IDX]) void'(mq.pop_front());
            if (e_ack) mq.push_back('{pc_i, 32'h0, mis, mis});
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mq.delete();
            m_disc = 0;
            check("r_req",   {31'b0, sram_if.req}, 32'h0);
            check("r_ack",   {31'b0, req_ack_o}, 32'h0);
            check("r_valid", {31'b0, id_valid_o}, 32'h0);
        end else begin
            model_step();
        end
    end

    task automatic drive(input bit ce, input logic [31:0] pc, input bit aok, input bit dok,
                         input logic [31:0] rd, input bit stl, input bit fl);
        ce_i            = ce;
        pc_i            = pc;
        sram_if.addr_ok = aok;
        sram_if.data_ok = dok;
        sram_if.rdata   = rd;
        stall           = stl ? 6'b000010 : 6'b000000;
        flush           = fl;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset holds everything quiet even with a valid fetch offered
        rst = 1'b1;
        drive(1'b1, RESET_PC, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        #1 rst = 1'b0;
        #1;
        check("t1_req_in_rst",   {31'b0, sram_if.req}, 32'h0);
        check("t1_ack_in_rst",   {31'b0, req_ack_o}, 32'h0);
        check("t1_valid_in_rst", {31'b0, id_valid_o}, 32'h0);
        tick();
        tick();

        // 2: back-to-back fetches with one-cycle data latency
        rst = 1'b1;
        drive(1'b1, 32'hbfc0_0000, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        check("t1_req_after_rst", {31'b0, sram_if.req}, 32'h1);
        check("t1_addr",          sram_if.addr, 32'hbfc0_0000);
        tick();
        drive(1'b1, 32'hbfc0_0004, 1'b1, 1'b1, 32'h3c08_bfc0, 1'b0, 1'b0);
        #1 check("t2_ack1", {31'b0, req_ack_o}, 32'h1);
        tick();
        drive(1'b0, 32'hbfc0_0008, 1'b0, 1'b1, 32'h2508_0010, 1'b0, 1'b0);
        #1;
        check("t2_valid0", {31'b0, id_valid_o}, 32'h1);
        check("t2_pc0",    id_pc_o, 32'hbfc0_0000);
        check("t2_inst0",  id_inst_o, 32'h3c08_bfc0);
        check("t2_exc0",   excepttype_o, 32'h0);
        tick();
        idle();
        #1;
        check("t2_valid1", {31'b0, id_valid_o}, 32'h1);
        check("t2_pc1",    id_pc_o, 32'hbfc0_0004);
        check("t2_inst1",  id_inst_o, 32'h2508_0010);
        tick();
        #1 check("t2_empty", {31'b0, id_valid_o}, 32'h0);
        tick();

        // 3: stall while full, then drain in order
        drive(1'b1, 32'hbfc0_0000, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'hbfc0_0004, 1'b1, 1'b1, 32'h3c08_bfc0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'hbfc0_0008, 1'b1, 1'b1, 32'h2508_0010, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t3_req_full", {31'b0, sram_if.req}, 32'h0);
            check("t3_ack_full", {31'b0, req_ack_o}, 32'h0);
            check("t3_pc_held",  id_pc_o, 32'hbfc0_0000);
            tick();
            drive(1'b1, 32'hbfc0_0008, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        end
        idle();
        #1 check("t3_pop0", id_pc_o, 32'hbfc0_0000);
        tick();
        #1 check("t3_pop1", id_pc_o, 32'hbfc0_0004);
        check("t3_inst1", id_inst_o, 32'h2508_0010);
        tick();

        // 4: flush with two requests in flight; their data must be dropped
        drive(1'b1, 32'hbfc0_0010, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'hbfc0_0014, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'hbfc0_0018, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        #1 check("t4_req_flush", {31'b0, sram_if.req}, 32'h0);
        tick();
        drive(1'b1, 32'hbfc0_0380, 1'b1, 1'b1, 32'haaaa_aaaa, 1'b0, 1'b0);
        #1 check("t4_full_by_discard", {31'b0, req_ack_o}, 32'h0);
        tick();
        drive(1'b1, 32'hbfc0_0380, 1'b1, 1'b1, 32'hbbbb_bbbb, 1'b0, 1'b0);
        #1 check("t4_new_pc_ack", {31'b0, req_ack_o}, 32'h1);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h4200_0018, 1'b0, 1'b0);
        #1 check("t4_not_yet", {31'b0, id_valid_o}, 32'h0);
        tick();
        idle();
        #1;
        check("t4_valid", {31'b0, id_valid_o}, 32'h1);
        check("t4_pc",    id_pc_o, 32'hbfc0_0380);
        check("t4_inst",  id_inst_o, 32'h4200_0018);
        tick();

        // 4b: data_ok in the flush cycle consumes the one outstanding response
        drive(1'b1, 32'hbfc0_0020, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'hcccc_cccc, 1'b0, 1'b1);
        tick();
        drive(1'b1, 32'hbfc0_0024, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        #1 check("t4b_ack", {31'b0, req_ack_o}, 32'h1);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'hdddd_dddd, 1'b0, 1'b0);
        tick();
        idle();
        #1;
        check("t4b_valid", {31'b0, id_valid_o}, 32'h1);
        check("t4b_inst",  id_inst_o, 32'hdddd_dddd);
        tick();

        // 5: misaligned fetch is tagged AdEL without touching memory
        drive(1'b1, 32'hbfc0_0002, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        check("t5_req", {31'b0, sram_if.req}, 32'h0);
        check("t5_ack", {31'b0, req_ack_o}, 32'h1);
        tick();
        idle();
        #1;
        check("t5_valid", {31'b0, id_valid_o}, 32'h1);
        check("t5_pc",    id_pc_o, 32'hbfc0_0002);
        check("t5_inst",  id_inst_o, 32'h0);
        check("t5_exc",   excepttype_o, 32'h0000_0010);
        tick();

        // 6: asynchronous reset with two entries queued under stall
        drive(1'b1, 32'hbfc0_0040, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'hbfc0_0044, 1'b1, 1'b1, 32'h1111_1111, 1'b1, 1'b0);
        tick();
        drive(1'b1, 32'hbfc0_0048, 1'b1, 1'b1, 32'h2222_2222, 1'b1, 1'b0);
        tick();
        drive(1'b1, 32'hbfc0_0048, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        #1 check("t6_valid_before", {31'b0, id_valid_o}, 32'h1);
        #1 rst = 1'b0;
        #1;
        check("t6_valid_async", {31'b0, id_valid_o}, 32'h0);
        check("t6_req_async",   {31'b0, sram_if.req}, 32'h0);
        check("t6_ack_async",   {31'b0, req_ack_o}, 32'h0);
        tick();
        idle();
        tick();

        // Recovery after reset: a fresh fetch goes straight through
        rst = 1'b1;
        drive(1'b1, RESET_PC, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        #1 check("t6_req_after", {31'b0, sram_if.req}, 32'h1);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h3c08_bfc0, 1'b0, 1'b0);
        tick();
        idle();
        #1;
        check("t6_valid_after", {31'b0, id_valid_o}, 32'h1);
        check("t6_pc_after",    id_pc_o, 32'hbfc0_0000);
        check("t6_inst_after",  id_inst_o, 32'h3c08_bfc0);
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
Instruction-fetch responder on the receiving end of the PC generator's pc/ce stream.
- Accepts fetch addresses and issues them on the SRAM-like instruction-memory interface (req/addr_ok/data_ok).
- Pairs in-order read data with its PC and buffers it in a small in-order queue.
- Presents {pc, inst, excepttype} to ID under IF stall and pipeline flush control.
- Sits between the PC register and the IF/ID stage.

Parameters:
ADDR_W, 32, instruction address width
DATA_W, 32, instruction width
DEPTH, 2, queue entries (max requests in flight plus buffered); power of two
STALL_W, 6, width of the stall bus
STALL_IDX, 1, stall bit that freezes IF output

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
pc_i  in  ADDR_W  fetch address from PC generator
ce_i  in  1  fetch enable from PC generator
req_ack_o  out  1  fetch accepted this cycle; PC generator advances only when high
stall  in  STALL_W  pipeline stall bus
flush  in  1  pipeline flush (exception/eret)
inst_sram_req  out  1  memory read request
inst_sram_addr  out  ADDR_W  memory read address (= pc_i)
inst_sram_addr_ok  in  1  address accepted
inst_sram_data_ok  in  1  read data valid, in request order
inst_sram_rdata  in  DATA_W  read data
id_valid_o  out  1  head entry valid toward ID
id_pc_o  out  ADDR_W  head PC
id_inst_o  out  DATA_W  head instruction
excepttype_o  out  32  head exception vector; bit 4 = AdEL on fetch

Behaviour:
- Reset (rst=0, async):
  - Queue empty; in-flight count and discard count zero.
  - All outputs 0.
  - The instruction memory is reset together with this block.
- Queue entry fields: {pc, inst, done, adel}.
  - Allocation is at tail on acceptance.
  - Fill is at the oldest not-done entry on data_ok.
  - Pop is at head.
- Request issue:
  - inst_sram_req = ce_i & ~flush & ~full & (pc_i[1:0]==0).
  - inst_sram_addr = pc_i, combinational.
- Acceptance:
  - Normal fetch: accepted when inst_sram_req & inst_sram_addr_ok. req_ack_o=1 in that cycle and a tail entry is allocated with done=0.
  - Misaligned fetch (ce_i & ~flush & ~full & pc_i[1:0]!=0): no memory request is issued. req_ack_o=1 and an entry is allocated with done=1, adel=1, inst=0.
- Response handling:
  - inst_sram_data_ok with discard count > 0: data dropped, discard count decrements.
  - Otherwise the response fills the oldest not-done entry; done is set the next edge.
  - data_ok with no pending entry and discard count 0 is ignored.
- Output and latency:
  - id_valid_o = head.done & ~flush.
  - id_pc_o, id_inst_o and excepttype_o are driven from head registers. excepttype_o = {27'b0, adel, 4'b0}.
  - Latency: data_ok in cycle M gives id_valid_o in cycle M+1. Zero-wait memory therefore yields one instruction per cycle.
- Pop:
  - Head pops when id_valid_o & ~stall[STALL_IDX].
  - While stalled, head outputs hold stable; responses still fill later entries.
- Flush:
  - In the flush cycle, every entry is invalidated at the edge.
  - Discard count becomes (current discard + allocated-not-done entries − data_ok-consumed-this-cycle). A data_ok arriving in the flush cycle is dropped.
  - No request is issued during flush.
  - The first request after flush is the new PC on the next cycle.
- Full and empty:
  - full = (entries + discard count) == DEPTH, so in-flight plus buffered never exceeds DEPTH.
  - When empty, id_valid_o=0.
- Simultaneous events:
  - Allocate, fill and pop in one cycle are all legal.
  - Pointers wrap modulo DEPTH.
  - Counters are log2(DEPTH)+1 bits wide and never exceed DEPTH.
- Reset mid-operation: all state clears immediately; outstanding responses are lost (memory is reset too).

Decomposition:
- Shared defines header:
  - InstAddrBus / InstBus widths
  - StallBus width and IF index
  - EXC_ADEL_BIT=4
  - reset PC 32'hbfc0_0000
- One natural sub-module, fetch_queue: the DEPTH-entry circular buffer with alloc/fill/pop/clear and occupancy.
- Handshake, discard counter and exception tagging stay in the top.

Test Plan:
1. Reset: hold rst=0 with ce_i=1, pc_i=bfc00000 -> inst_sram_req=0, req_ack_o=0, id_valid_o=0; release -> req=1 with addr bfc00000 next cycle.
2. Back-to-back: pc bfc00000/bfc00004, addr_ok=1 each cycle, data_ok one cycle later with 3c08bfc0/25080010 -> id_valid_o on consecutive cycles with id_pc_o/id_inst_o matching, excepttype_o=0.
3. Stall: stall[1]=1 for 3 cycles after two fills -> req deasserted (full), req_ack_o=0, id_pc_o held at bfc00000; release -> bfc00000 then bfc00004 pop on successive cycles.
4. Flush in flight: two requests accepted, no data yet, flush=1 -> two later data_ok (rdata aaaaaaaa, bbbbbbbb) dropped; next fetch pc bfc00380 returns 42000018 -> first id_valid_o shows pc bfc00380, inst 42000018.
5. Misaligned: pc_i=bfc00002 -> no inst_sram_req, req_ack_o=1, next cycle id_valid_o=1, id_inst_o=0, excepttype_o=00000010.
6. Async reset: assert rst=0 mid-cycle with 2 entries queued -> id_valid_o and inst_sram_req drop to 0 without waiting for a clock edge.
